// File: rtl/comp_8_serial_pkg.sv
// Shared parameters and types for the serial magnitude comparator.
package comp_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DIGIT_DEF = 2;
  localparam int NDIG_DEF  = WIDTH_DEF / DIGIT_DEF;
  localparam int CNT_W     = (NDIG_DEF > 1) ? $clog2(NDIG_DEF) : 1;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/comp_8_serial_if.sv
// Operand/result bundle. There is no handshake: operands are sampled once on the
// first rst_n-high edge, and g/e are final once the block reaches DONE.
interface comp_8_serial_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             g;
  logic             e;

  modport master (output ina, inb, input g, e);
  modport slave  (input ina, inb, output g, e);
endinterface

// File: rtl/comp_8_serial_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module comp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             eq
);
  assign gt = (a > b);
  assign eq = (a == b);
endmodule

// File: rtl/comp_8_serial.sv
// Serial MSB-first magnitude comparator: one DIGIT-bit slice per clock, sticky
// decision once a difference is seen, result registered and held in DONE.
module comp_8_serial
  import comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  comp_8_serial_if.slave  bus,
  output state_t          dbg_state
);
  localparam int NDIG = WIDTH / DIGIT;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, sa_nx, sb_nx;
  logic             gt, eq, gt_nx, eq_nx;
  logic             g_q, e_q, g_nx, e_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [DIGIT-1:0] da, db;
  logic             d_gt, d_eq;

  // In ARM the top digit comes straight from the operands being captured.
  assign da = (state == ARM) ? bus.ina[WIDTH-1 -: DIGIT] : sa[WIDTH-1 -: DIGIT];
  assign db = (state == ARM) ? bus.inb[WIDTH-1 -: DIGIT] : sb[WIDTH-1 -: DIGIT];

  comp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (da),
    .b  (db),
    .gt (d_gt),
    .eq (d_eq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARM;
      sa    <= '0;
      sb    <= '0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      cnt   <= '0;
      g_q   <= 1'b0;
      e_q   <= 1'b0;
    end else begin
      state <= state_nx;
      sa    <= sa_nx;
      sb    <= sb_nx;
      gt    <= gt_nx;
      eq    <= eq_nx;
      cnt   <= cnt_nx;
      g_q   <= g_nx;
      e_q   <= e_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sa_nx    = sa;
    sb_nx    = sb;
    gt_nx    = gt;
    eq_nx    = eq;
    cnt_nx   = cnt;
    g_nx     = g_q;
    e_nx     = e_q;
    unique case (state)
      ARM: begin
        sa_nx    = bus.ina << DIGIT;
        sb_nx    = bus.inb << DIGIT;
        gt_nx    = d_gt;
        eq_nx    = d_eq;
        cnt_nx   = CNT_W'(NDIG - 1);
        state_nx = RUN;
      end
      RUN: begin
        if (cnt != '0) begin
          // Only an undecided comparison looks at further digits.
          if (eq && !d_eq) begin
            gt_nx = d_gt;
            eq_nx = 1'b0;
          end
          sa_nx  = sa << DIGIT;
          sb_nx  = sb << DIGIT;
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          g_nx     = gt;
          e_nx     = eq;
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = ARM;
      end
    endcase
  end

  assign bus.g     = g_q;
  assign bus.e     = e_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_comp_8_serial.sv
// Self-checking bench for comp_8_serial against an arithmetic reference compare.
module tb_comp_8_serial;
  import comp_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_tests;
  int     n_fail;
  logic [1:0] exp_q[$];

  comp_8_serial_if #(.WIDTH(W)) bus ();

  comp_8_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // g and e together is never legal
  always @(negedge clk) begin
    n_tests++;
    if (bus.g && bus.e) begin
      n_fail++;
      $display("FAIL g_and_e: got g=%0b e=%0b, required not both 1", bus.g, bus.e);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
  endtask

  // Reference model: plain unsigned compare -> {g, e}
  task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back({(a > b), (a == b)});
  endtask

  // Reset, load operands, release; returns after edge 5.
  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    hold_reset(1);
    bus.ina = a;
    bus.inb = b;
    rst_n   = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_reset();
    bus.ina = 8'hFF;
    bus.inb = 8'h00;
    rst_n   = 1'b0;
    step();
    n_tests++;
    if ({bus.g, bus.e} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_first_edge: got g,e=%b, required 00", {bus.g, bus.e});
    end
    repeat (4) step();
    n_tests++;
    if ({bus.g, bus.e} !== 2'b00 || dbg_state !== ARM) begin
      n_fail++;
      $display("FAIL reset_held: got g,e=%b state=%0d, required 00 state=0", {bus.g, bus.e}, dbg_state);
    end
  endtask

  task automatic test_equal();
    logic [1:0] exp;
    hold_reset(1);
    bus.ina = 8'h01;
    bus.inb = 8'h01;
    push_expected(8'h01, 8'h01);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_tests++;
      if ({bus.g, bus.e} !== 2'b00) begin
        n_fail++;
        $display("FAIL equal_early_edge%0d: got g,e=%b, required 00", k, {bus.g, bus.e});
      end
    end
    step();
    exp = exp_q.pop_front();
    n_tests++;
    if ({bus.g, bus.e} !== exp) begin
      n_fail++;
      $display("FAIL equal_result: got g,e=%b, required %b", {bus.g, bus.e}, exp);
    end
  endtask

  task automatic test_less_stable();
    logic [1:0] exp;
    hold_reset(5);
    n_tests++;
    if ({bus.g, bus.e} !== 2'b00) begin
      n_fail++;
      $display("FAIL less_after_reset: got g,e=%b, required 00", {bus.g, bus.e});
    end
    bus.ina = 8'h02;
    bus.inb = 8'h04;
    push_expected(8'h02, 8'h04);
    rst_n = 1'b1;
    repeat (5) step();
    exp = exp_q.pop_front();
    for (int k = 0; k <= 10; k++) begin
      n_tests++;
      if ({bus.g, bus.e} !== exp) begin
        n_fail++;
        $display("FAIL less_stable_edge%0d: got g,e=%b, required %b", 5 + k, {bus.g, bus.e}, exp);
      end
      step();
    end
  endtask

  task automatic test_last_digit();
    logic [1:0] exp;
    push_expected(8'hA5, 8'hA4);
    run_pair(8'hA5, 8'hA4);
    exp = exp_q.pop_front();
    n_tests++;
    if ({bus.g, bus.e} !== exp) begin
      n_fail++;
      $display("FAIL last_digit_gt: got g,e=%b, required %b", {bus.g, bus.e}, exp);
    end
    push_expected(8'hA4, 8'hA5);
    run_pair(8'hA4, 8'hA5);
    exp = exp_q.pop_front();
    n_tests++;
    if ({bus.g, bus.e} !== exp) begin
      n_fail++;
      $display("FAIL last_digit_lt: got g,e=%b, required %b", {bus.g, bus.e}, exp);
    end
  endtask

  task automatic test_frozen_inputs();
    logic [1:0] exp;
    hold_reset(1);
    bus.ina = 8'h80;
    bus.inb = 8'h7F;
    push_expected(8'h80, 8'h7F);
    rst_n = 1'b1;
    step();
    // operands change every edge after capture
    repeat (4) begin
      bus.ina = W'($urandom);
      bus.inb = W'($urandom);
      step();
    end
    exp = exp_q.pop_front();
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if ({bus.g, bus.e} !== exp) begin
        n_fail++;
        $display("FAIL frozen_inputs_%0d: got g,e=%b, required %b", k, {bus.g, bus.e}, exp);
      end
      bus.ina = W'($urandom);
      bus.inb = W'($urandom);
      step();
    end
  endtask

  task automatic test_abort();
    logic [1:0] exp;
    hold_reset(1);
    bus.ina = 8'hFF;
    bus.inb = 8'h00;
    rst_n   = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    n_tests++;
    if ({bus.g, bus.e} !== 2'b00 || dbg_state !== ARM) begin
      n_fail++;
      $display("FAIL abort: got g,e=%b state=%0d, required 00 state=0", {bus.g, bus.e}, dbg_state);
    end
    bus.ina = 8'h33;
    bus.inb = 8'h33;
    push_expected(8'h33, 8'h33);
    rst_n = 1'b1;
    repeat (5) step();
    exp = exp_q.pop_front();
    n_tests++;
    if ({bus.g, bus.e} !== exp) begin
      n_fail++;
      $display("FAIL abort_restart: got g,e=%b, required %b", {bus.g, bus.e}, exp);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [1:0]   exp;
    for (int i = 0; i < 500; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      push_expected(a, b);
      run_pair(a, b);
      exp = exp_q.pop_front();
      n_tests++;
      if ({bus.g, bus.e} !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h got g,e=%b, required %b", i, a, b, {bus.g, bus.e}, exp);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.ina = '0;
    bus.inb = '0;
    test_reset();
    test_equal();
    test_less_stable();
    test_last_digit();
    test_frozen_inputs();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
